// File: rtl/fir_sample_feeder_pkg.sv
// Shared definitions for the FIR sample feeder: FSM encoding, default widths
// and a parameter-check helper.
package fir_feeder_pkg;

  localparam int DEF_BIT_WIDTH     = 16;
  localparam int DEF_FIFO_DEPTH    = 8;
  localparam int DEF_OVF_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_RUN  = 2'd2
  } feeder_state_e;

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fir_sample_feeder_if.sv
// Signal bundle between the feeder, the ADC front end, the filter and downstream.
// OVF_CNT exists only when FIR_FEEDER_OVF_CNT_EN is defined.
interface fir_sample_feeder_if
  import fir_feeder_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH
`ifdef FIR_FEEDER_OVF_CNT_EN
  , parameter int OVF_CNT_WIDTH = DEF_OVF_CNT_WIDTH
`endif
);
  logic                 ADC_VALID;
  logic [BIT_WIDTH-1:0] ADC_DATA;
  logic                 FIR_START;
  logic [BIT_WIDTH-1:0] FIR_DATA_IN;
  logic                 FIR_RDY;
  logic [BIT_WIDTH-1:0] FIR_DATA_OUT;
  logic                 OUT_VALID;
  logic [BIT_WIDTH-1:0] OUT_DATA;
  logic                 FIFO_EMPTY;
  logic                 FIFO_FULL;
  logic                 OVF_CLR;
  logic                 OVF_FLAG;
`ifdef FIR_FEEDER_OVF_CNT_EN
  logic [OVF_CNT_WIDTH-1:0] OVF_CNT;
`endif

  modport slave (
    input  ADC_VALID, ADC_DATA, FIR_RDY, FIR_DATA_OUT, OVF_CLR,
    output FIR_START, FIR_DATA_IN, OUT_VALID, OUT_DATA, FIFO_EMPTY, FIFO_FULL,
`ifdef FIR_FEEDER_OVF_CNT_EN
    output OVF_CNT,
`endif
    output OVF_FLAG
  );

  modport master (
    output ADC_VALID, ADC_DATA, FIR_RDY, FIR_DATA_OUT, OVF_CLR,
    input  FIR_START, FIR_DATA_IN, OUT_VALID, OUT_DATA, FIFO_EMPTY, FIFO_FULL,
`ifdef FIR_FEEDER_OVF_CNT_EN
    input  OVF_CNT,
`endif
    input  OVF_FLAG
  );
endinterface

// File: rtl/fir_sample_feeder_fifo.sv
// Power-of-two synchronous FIFO; a push while full is accepted only together
// with a pop. Overflow accounting is left to the instantiating block.
module fifo_sync #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/fir_sample_feeder.sv
// Buffers ADC samples and launches one FIR run per sample via START/READY.
// FIR_FEEDER_OVF_CNT_EN builds the saturating OVF_CNT drop counter.
//
// state  | meaning
// S_IDLE | waiting for a queued sample and an idle filter
// S_ACK  | START issued, waiting for the filter to drop FIR_RDY
// S_RUN  | filter busy, waiting for FIR_RDY to return, then capture
module fir_sample_feeder
  import fir_feeder_pkg::*;
#(
  parameter int BIT_WIDTH     = DEF_BIT_WIDTH,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int OVF_CNT_WIDTH = DEF_OVF_CNT_WIDTH
) (
  input logic             CLK,
  input logic             RST,
  fir_sample_feeder_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if (!is_pow2(FIFO_DEPTH) || OVF_CNT_WIDTH < 1) begin : g_bad_param
    $error("fir_sample_feeder: FIFO_DEPTH must be a power of two >= 2");
  end

  feeder_state_e        state, state_nxt;
  logic                 pop;
  logic                 capture;
  logic                 drop;
  logic [BIT_WIDTH-1:0] fifo_rd_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic                 fir_start;
  logic [BIT_WIDTH-1:0] fir_data_in;
  logic                 out_valid;
  logic [BIT_WIDTH-1:0] out_data;
  logic                 ovf_flag;

  fifo_sync #(.WIDTH(BIT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push    (bus.ADC_VALID),
    .pop     (pop),
    .wr_data (bus.ADC_DATA),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign drop = bus.ADC_VALID && (fifo_count == CW'(FIFO_DEPTH)) && !pop;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: if (!fifo_empty && bus.FIR_RDY) begin
        pop       = 1'b1;
        state_nxt = S_ACK;
      end
      S_ACK:  if (!bus.FIR_RDY) state_nxt = S_RUN;
      S_RUN:  if (bus.FIR_RDY) begin
        capture   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      fir_start   <= 1'b0;
      fir_data_in <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
    end else begin
      state     <= state_nxt;
      fir_start <= pop;
      out_valid <= capture;
      if (pop)     fir_data_in <= fifo_rd_data;
      if (capture) out_data    <= bus.FIR_DATA_OUT;
    end
  end

  // A drop outranks a simultaneous clear.
  always_ff @(posedge CLK) begin
    if (RST)              ovf_flag <= 1'b0;
    else if (drop)        ovf_flag <= 1'b1;
    else if (bus.OVF_CLR) ovf_flag <= 1'b0;
  end

`ifdef FIR_FEEDER_OVF_CNT_EN
  logic [OVF_CNT_WIDTH-1:0] ovf_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf_cnt <= '0;
    end else if (drop) begin
      if (bus.OVF_CLR)     ovf_cnt <= OVF_CNT_WIDTH'(1);
      else if (~&ovf_cnt)  ovf_cnt <= ovf_cnt + 1'b1;
    end else if (bus.OVF_CLR) begin
      ovf_cnt <= '0;
    end
  end

  assign bus.OVF_CNT = ovf_cnt;
`endif

  assign bus.FIR_START   = fir_start;
  assign bus.FIR_DATA_IN = fir_data_in;
  assign bus.OUT_VALID   = out_valid;
  assign bus.OUT_DATA    = out_data;
  assign bus.FIFO_EMPTY  = fifo_empty;
  assign bus.FIFO_FULL   = fifo_full;
  assign bus.OVF_FLAG    = ovf_flag;
endmodule

// File: tb/tb_fir_sample_feeder.sv
// Bench for fir_sample_feeder: filter model with B=20 and result = sample+1,
// queue-based reference model, table vectors and randomized traffic.
module tb_fir_sample_feeder;
  localparam int B     = 20;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  fir_sample_feeder_if #(.BIT_WIDTH(16)) bus();

  fir_sample_feeder #(.BIT_WIDTH(16), .FIFO_DEPTH(DEPTH), .OVF_CNT_WIDTH(16)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural filter: RDY low for exactly B cycles, result read at the end.
  logic        f_rdy = 1'b1;
  logic        f_busy = 1'b0;
  int          f_cnt = 0;
  logic [15:0] f_res = '0;
  logic [15:0] f_held = '0;
  int          unstable = 0;

  assign bus.FIR_RDY      = f_rdy;
  assign bus.FIR_DATA_OUT = f_res;

  always @(posedge clk) begin
    if (rst) begin
      f_rdy  <= 1'b1;
      f_busy <= 1'b0;
      f_cnt  <= 0;
    end else if (f_busy) begin
      if (bus.FIR_DATA_IN !== f_held) unstable <= unstable + 1;
      if (f_cnt == 0) begin
        f_rdy  <= 1'b1;
        f_busy <= 1'b0;
        f_res  <= bus.FIR_DATA_IN + 16'd1;
      end else begin
        f_cnt <= f_cnt - 1;
      end
    end else if (bus.FIR_START) begin
      f_busy <= 1'b1;
      f_rdy  <= 1'b0;
      f_cnt  <= B - 1;
      f_held <= bus.FIR_DATA_IN;
    end
  end

  // Reference model: FIFO as a queue; a launch can happen one edge after
  // arrival and no sooner than B+3 edges after the previous launch.
  typedef struct { int cyc; logic [15:0] data; } exp_t;
  logic [15:0] pend[$];
  exp_t        exp_q[$];
  int          next_free = 0;
  bit          mflag = 1'b0;
  int          mcnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_edge(input int e, input bit v, input logic [15:0] d, input bit c);
    int occ = pend.size();
    bit pop = (occ > 0) && (e >= next_free);
    if (pop) begin
      exp_t x;
      x.cyc  = e + B + 2;
      x.data = pend.pop_front() + 16'd1;
      exp_q.push_back(x);
      next_free = e + B + 3;
    end
    if (v && (occ < DEPTH || pop)) begin
      pend.push_back(d);
    end else if (v) begin
      mflag = 1'b1;
      mcnt  = c ? 1 : ((mcnt < 65535) ? mcnt + 1 : mcnt);
    end else if (c) begin
      mflag = 1'b0;
      mcnt  = 0;
    end
    if (v && (occ < DEPTH || pop) && c) begin
      mflag = 1'b0;
      mcnt  = 0;
    end
  endtask

  task automatic model_reset();
    pend.delete();
    exp_q.delete();
    next_free = 0;
    mflag = 1'b0;
    mcnt  = 0;
  endtask

  task automatic step(input bit v, input logic [15:0] d, input bit c);
    bus.ADC_VALID = v;
    bus.ADC_DATA  = d;
    bus.OVF_CLR   = c;
    model_edge(cyc + 1, v, d, c);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int i = 0;
    while ((exp_q.size() > 0 || pend.size() > 0) && i < budget) begin
      step(1'b0, 16'h0, 1'b0);
      i++;
    end
    check("drain_done", exp_q.size() + pend.size(), 0);
    step(1'b0, 16'h0, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_fir_start"},  bus.FIR_START, 0);
    check({tag, "_fir_din"},    bus.FIR_DATA_IN, 0);
    check({tag, "_out_valid"},  bus.OUT_VALID, 0);
    check({tag, "_out_data"},   bus.OUT_DATA, 0);
    check({tag, "_fifo_empty"}, bus.FIFO_EMPTY, 1);
    check({tag, "_fifo_full"},  bus.FIFO_FULL, 0);
    check({tag, "_ovf_flag"},   bus.OVF_FLAG, 0);
`ifdef FIR_FEEDER_OVF_CNT_EN
    check({tag, "_ovf_cnt"},    bus.OVF_CNT, 0);
`endif
  endtask

  // Result monitor: every OUT_VALID must match the next expected result and cycle.
  always @(negedge clk) begin
    bit due;
    if (!rst) begin
      due = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      if (due || bus.OUT_VALID) begin
        check("out_valid_timing", bus.OUT_VALID, due);
        if (due) begin
          check("out_data", bus.OUT_DATA, exp_q[0].data);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  typedef struct {
    bit          v;
    logic [15:0] d;
    bit          clr;
    bit          e_empty;
    bit          e_full;
    bit          e_flag;
    int          e_cnt;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int n;
    for (int i = 0; i < 10; i++)
      tbl[i] = '{1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0, (i >= 8), (i == 9), (i == 9) ? 1 : 0};
    tbl[10] = '{1'b1, 16'hC0AA, 1'b1, 1'b0, 1'b1, 1'b1, 1};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 0};

    bus.ADC_VALID = 1'b0;
    bus.ADC_DATA  = '0;
    bus.OVF_CLR   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;

    // Single sample on an idle feeder.
    step(1'b1, 16'h1234, 1'b0);
    check("t1_start_e0", bus.FIR_START, 0);
    step(1'b0, 16'h0, 1'b0);
    check("t1_start_e1", bus.FIR_START, 1);
    check("t1_din_e1", bus.FIR_DATA_IN, 16'h1234);
    step(1'b0, 16'h0, 1'b0);
    check("t1_start_e2", bus.FIR_START, 0);
    n = 2;
    while (!bus.OUT_VALID && n < 40) begin
      step(1'b0, 16'h0, 1'b0);
      n++;
    end
    check("t1_latency", n, 23);
    check("t1_out_data", bus.OUT_DATA, 16'h1235);
    check("t1_din_hold", bus.FIR_DATA_IN, 16'h1234);
    step(1'b0, 16'h0, 1'b0);
    check("t1_valid_pulse", bus.OUT_VALID, 0);
    check("t1_out_hold", bus.OUT_DATA, 16'h1235);

    // Filter busy, then 8 back-to-back samples fill the FIFO without drops.
    step(1'b1, 16'hA000, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 16'hB000 + 16'(i), 1'b0);
    check("t2_full", bus.FIFO_FULL, 1);
    check("t2_no_drop", bus.OVF_FLAG, 0);
    drain(400);

    // Table: 10 back-to-back samples, clear colliding with a drop, clear alone.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].clr);
      check($sformatf("tbl%0d_empty", i), bus.FIFO_EMPTY, tbl[i].e_empty);
      check($sformatf("tbl%0d_full", i),  bus.FIFO_FULL,  tbl[i].e_full);
      check($sformatf("tbl%0d_flag", i),  bus.OVF_FLAG,   tbl[i].e_flag);
`ifdef FIR_FEEDER_OVF_CNT_EN
      check($sformatf("tbl%0d_cnt", i),   bus.OVF_CNT,    tbl[i].e_cnt);
`endif
    end
    drain(400);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 4) == 0, 16'($urandom), $urandom_range(0, 49) == 0);
      check("rnd_empty", bus.FIFO_EMPTY, pend.size() == 0);
      check("rnd_full",  bus.FIFO_FULL,  pend.size() == DEPTH);
      check("rnd_flag",  bus.OVF_FLAG,   mflag);
`ifdef FIR_FEEDER_OVF_CNT_EN
      check("rnd_cnt",   bus.OVF_CNT,    mcnt);
`endif
    end
    drain(400);
    step(1'b0, 16'h0, 1'b1);

    // Reset while the filter is running with 3 samples queued.
    step(1'b1, 16'hD000, 1'b0);
    for (int i = 1; i < 4; i++) step(1'b1, 16'hD000 + 16'(i), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b0);
    check("t5_queued", pend.size(), 3);
    check("t5_filter_busy", bus.FIR_RDY, 0);
    bus.ADC_VALID = 1'b0;
    bus.OVF_CLR   = 1'b0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_vals("t5_rst");
    rst = 1'b0;
    for (int i = 0; i < 30; i++) step(1'b0, 16'h0, 1'b0);
    check_reset_vals("t5_after");
    step(1'b1, 16'hE000, 1'b0);
    drain(100);
    check("t5_new_result", bus.OUT_DATA, 16'hE001);

    check("din_stable", unstable, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
